// File: rtl/pwm_capture_if.sv
// Result handshake between pwm_capture (master) and its consumer (slave).
// Carries one period/high-time measurement per valid/ready transfer.
interface pwm_capture_if #(
    parameter int unsigned CntDw = 16
);
    logic             meas_valid;
    logic             meas_ready;
    logic [CntDw-1:0] period;
    logic [CntDw-1:0] high;

    modport master (
        output meas_valid,
        output period,
        output high,
        input  meas_ready
    );

    modport slave (
        input  meas_valid,
        input  period,
        input  high,
        output meas_ready
    );
endinterface

// File: rtl/pwm_capture.sv
// Single-channel PWM capture: synchronise, deglitch, measure period/high time.
// Optional glitch filter built only when PWM_CAPTURE_FILTER_EN is defined.
module pwm_capture #(
    parameter int unsigned CntDw  = 16,
    parameter int unsigned FiltDw = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              pwm_i,
    input  logic [FiltDw-1:0] filt_thresh_i,
    pwm_capture_if.master     meas,
    output logic              lost_o,
    output logic              timeout_o
);

    localparam logic [CntDw-1:0] CntMax = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_HIGH,
        ST_LOW
    } state_e;

    state_e           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_filt_q;
    logic             r_filt_d;
    logic             r_need_fall;
    logic [CntDw-1:0] r_pcnt;
    logic [CntDw-1:0] r_hcnt;
    logic [CntDw-1:0] r_hlat;
    logic             w_rise;
    logic             w_fall;
    logic             w_accept;

    // Two-flop synchroniser on the asynchronous input.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pwm_i;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    logic [FiltDw-1:0] r_run;

    // Accept a new level only after it persists for threshold+1 samples.
    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            r_filt_q <= 1'b0;
            r_run    <= '0;
        end else if (r_sync2 == r_filt_q) begin
            r_run <= '0;
        end else if (r_run == filt_thresh_i) begin
            r_filt_q <= r_sync2;
            r_run    <= '0;
        end else begin
            r_run <= r_run + FiltDw'(1);
        end
    end
`else
    logic w_unused_thresh;
    assign w_unused_thresh = ^filt_thresh_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            r_filt_q <= 1'b0;
        end else begin
            r_filt_q <= r_sync2;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            r_filt_d <= 1'b0;
        end else begin
            r_filt_d <= r_filt_q;
        end
    end

    assign w_rise   = r_filt_q & ~r_filt_d;
    assign w_fall   = ~r_filt_q & r_filt_d;
    assign w_accept = meas.meas_valid & meas.meas_ready;

    // Measurement FSM and registered result/pulse outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state         <= ST_IDLE;
            r_need_fall     <= 1'b0;
            r_pcnt          <= '0;
            r_hcnt          <= '0;
            r_hlat          <= '0;
            meas.meas_valid <= 1'b0;
            meas.period     <= '0;
            meas.high       <= '0;
            lost_o          <= 1'b0;
            timeout_o       <= 1'b0;
        end else begin
            lost_o    <= 1'b0;
            timeout_o <= 1'b0;
            if (w_accept) begin
                meas.meas_valid <= 1'b0;
            end

            if (!en_i) begin
                r_state     <= ST_IDLE;
                r_need_fall <= 1'b0;
                r_pcnt      <= '0;
                r_hcnt      <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        // Input already high at enable: its first filtered rise is not a real edge.
                        r_state     <= ST_ARM;
                        r_need_fall <= r_sync2;
                    end
                    ST_ARM: begin
                        if (r_need_fall) begin
                            if (w_fall) begin
                                r_need_fall <= 1'b0;
                            end
                        end else if (w_rise) begin
                            r_state <= ST_HIGH;
                            r_pcnt  <= CntDw'(1);
                            r_hcnt  <= CntDw'(1);
                        end
                    end
                    ST_HIGH: begin
                        if (r_pcnt == CntMax) begin
                            timeout_o <= 1'b1;
                            r_pcnt    <= '0;
                            r_hcnt    <= '0;
                            r_state   <= ST_ARM;
                        end else if (w_fall) begin
                            r_hlat  <= r_hcnt;
                            r_pcnt  <= r_pcnt + CntDw'(1);
                            r_state <= ST_LOW;
                        end else begin
                            r_pcnt <= r_pcnt + CntDw'(1);
                            r_hcnt <= r_hcnt + CntDw'(1);
                        end
                    end
                    ST_LOW: begin
                        if (w_rise) begin
                            // A result being taken this cycle frees the slot for the new one.
                            if (!meas.meas_valid || w_accept) begin
                                meas.meas_valid <= 1'b1;
                                meas.period     <= r_pcnt;
                                meas.high       <= r_hlat;
                            end else begin
                                lost_o <= 1'b1;
                            end
                            r_pcnt  <= CntDw'(1);
                            r_hcnt  <= CntDw'(1);
                            r_state <= ST_HIGH;
                        end else if (r_pcnt == CntMax) begin
                            timeout_o <= 1'b1;
                            r_pcnt    <= '0;
                            r_hcnt    <= '0;
                            r_state   <= ST_ARM;
                        end else begin
                            r_pcnt <= r_pcnt + CntDw'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: waveforms described as level runs,
// expected results derived from run lengths and compared every cycle.
module tb_pwm_capture;

    localparam int unsigned CNT_DW  = 8;
    localparam int unsigned FILT_DW = 4;
    localparam int          TO_LIM  = (1 << CNT_DW) - 1;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam bit FILT_BUILT = 1'b1;
`else
    localparam bit FILT_BUILT = 1'b0;
`endif

    typedef struct {
        bit lvl;
        int len;
    } run_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               pwm;
    logic [FILT_DW-1:0] thresh;
    logic               lost;
    logic               tout;

    pwm_capture_if #(.CntDw(CNT_DW)) meas_if ();

    pwm_capture #(
        .CntDw (CNT_DW),
        .FiltDw(FILT_DW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .pwm_i        (pwm),
        .filt_thresh_i(thresh),
        .meas         (meas_if),
        .lost_o       (lost),
        .timeout_o    (tout)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    n_lost_seen = 0;
    int    n_tout_seen = 0;
    string ph = "init";

    // Reference output state and scheduled events keyed by clock edge number.
    bit    m_valid = 1'b0;
    int    m_period = 0;
    int    m_high = 0;
    bit    m_lost = 1'b0;
    bit    m_tout = 1'b0;
    int    ev_p[int];
    int    ev_h[int];
    bit    ev_t[int];
    run_t  runs[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    function automatic bit rdy_for(input int mode, input int k, input int off);
        case (mode)
            0:       return 1'b1;
            1:       return 1'($urandom_range(0, 1));
            2:       return k == off;
            default: return 1'b0;
        endcase
    endfunction

    // One clock: drive inputs, advance, update reference, compare outputs.
    task automatic step(input bit rst_v, input bit en_v, input bit pwm_v, input bit rdy_v);
        rst = rst_v;
        en  = en_v;
        pwm = pwm_v;
        meas_if.meas_ready = rdy_v;
        @(posedge clk);
        cyc++;
        if (rst_v) begin
            m_valid  = 1'b0;
            m_period = 0;
            m_high   = 0;
            m_lost   = 1'b0;
            m_tout   = 1'b0;
        end else begin
            m_lost = 1'b0;
            m_tout = ev_t.exists(cyc);
            if (ev_p.exists(cyc)) begin
                if (!m_valid || rdy_v) begin
                    m_valid  = 1'b1;
                    m_period = ev_p[cyc];
                    m_high   = ev_h[cyc];
                end else begin
                    m_lost = 1'b1;
                end
            end else if (m_valid && rdy_v) begin
                m_valid = 1'b0;
            end
        end
        #1;
        check({ph, ".valid"},   32'(meas_if.meas_valid), 32'(m_valid));
        check({ph, ".period"},  32'(meas_if.period),     32'(m_period));
        check({ph, ".high"},    32'(meas_if.high),       32'(m_high));
        check({ph, ".lost"},    32'(lost),               32'(m_lost));
        check({ph, ".timeout"}, 32'(tout),               32'(m_tout));
        if (lost === 1'b1) n_lost_seen++;
        if (tout === 1'b1) n_tout_seen++;
    endtask

    task automatic add_run(input bit lvl, input int len);
        run_t r;
        r.lvl = lvl;
        r.len = len;
        runs.push_back(r);
    endtask

    task automatic add_pwm(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            add_run(1'b1, hi);
            add_run(1'b0, lo);
        end
    endtask

    // Drive the current run list with enable high; rst_off>0 ends it with a reset.
    task automatic run_phase(input int th, input int mode, input int rdy_off, input int rst_off);
        bit   w[$];
        run_t m[$];
        int   eff_th, len, e0, d_edge, pos, last, lasthigh, edge_n;
        bit   armed, changed;

        eff_th = FILT_BUILT ? th : 0;
        foreach (runs[i]) for (int j = 0; j < runs[i].len; j++) w.push_back(runs[i].lvl);
        len = (rst_off > 0) ? rst_off : w.size();
        n_lost_seen = 0;
        n_tout_seen = 0;
        thresh = FILT_DW'(th);
        for (int k = -4; k < 0; k++) step(1'b0, 1'b0, w[0], rdy_for(mode, k, rdy_off));
        e0     = cyc + 1;
        d_edge = e0 + len;

        // Runs shorter than the filter window vanish into their neighbours.
        m = runs;
        changed = 1'b1;
        while (changed) begin
            changed = 1'b0;
            for (int i = 1; i < m.size() - 1; i++) begin
                if (m[i].len < eff_th + 1) begin
                    m[i-1].len = m[i-1].len + m[i].len + m[i+1].len;
                    m.delete(i + 1);
                    m.delete(i);
                    changed = 1'b1;
                    break;
                end
            end
        end

        // Rise-to-rise distances give results; a gap beyond the counter limit times out.
        pos = 0; last = 0; lasthigh = 0; armed = 1'b0;
        foreach (m[i]) begin
            if (i > 0 && m[i].lvl && !m[i-1].lvl) begin
                if (armed && pos - last <= TO_LIM) begin
                    edge_n = e0 + pos + 3 + eff_th;
                    if (edge_n < d_edge) begin
                        ev_p[edge_n] = pos - last;
                        ev_h[edge_n] = lasthigh;
                    end
                end else if (armed) begin
                    edge_n = e0 + last + TO_LIM + 3 + eff_th;
                    if (edge_n < d_edge) ev_t[edge_n] = 1'b1;
                end
                armed    = 1'b1;
                last     = pos;
                lasthigh = m[i].len;
            end
            pos += m[i].len;
        end
        if (armed) begin
            edge_n = e0 + last + TO_LIM + 3 + eff_th;
            if (edge_n < d_edge && pos - last > TO_LIM) ev_t[edge_n] = 1'b1;
        end

        for (int k = 0; k < len; k++) step(1'b0, 1'b1, w[k], rdy_for(mode, k, rdy_off));
        if (rst_off > 0) step(1'b1, 1'b1, w[len], 1'b0);
        for (int k = len + 1; k < len + 7; k++) step(1'b0, 1'b0, w[len-1], rdy_for(mode, k, rdy_off));
        runs.delete();
    endtask

    initial begin
        int th, np, lvl;

        rst = 1'b1; en = 1'b0; pwm = 1'b0; thresh = '0;
        meas_if.meas_ready = 1'b0;
        ph = "reset";
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b1);

        ph = "p10h3_th2";
        add_run(1'b0, 6); add_pwm(5, 3, 7); add_run(1'b1, 3); add_run(1'b0, 8);
        run_phase(2, 0, 0, 0);

        ph = "glitch_th1";
        add_run(1'b0, 6);
        for (int i = 0; i < 4; i++) begin
            add_run(1'b1, 3); add_run(1'b0, 3); add_run(1'b1, 1); add_run(1'b0, 3);
        end
        add_run(1'b1, 3); add_run(1'b0, 8);
        run_phase(1, 0, 0, 0);

        ph = "glitch_th0";
        add_run(1'b0, 6);
        for (int i = 0; i < 4; i++) begin
            add_run(1'b1, 3); add_run(1'b0, 3); add_run(1'b1, 1); add_run(1'b0, 3);
        end
        add_run(1'b1, 3); add_run(1'b0, 8);
        run_phase(0, 0, 0, 0);

        ph = "backpressure";
        add_run(1'b0, 6); add_pwm(4, 3, 7); add_run(1'b1, 3); add_run(1'b0, 8);
        run_phase(0, 2, 42, 0);
        check("bp.lost_count", 32'(n_lost_seen), 32'd2);
        check("bp.held_valid", 32'(meas_if.meas_valid), 32'd1);
        check("bp.held_period", 32'(meas_if.period), 32'd10);
        check("bp.held_high", 32'(meas_if.high), 32'd3);

        ph = "timeout";
        add_run(1'b0, 6); add_run(1'b1, 300); add_run(1'b0, 15);
        add_pwm(2, 5, 15); add_run(1'b1, 5); add_run(1'b0, 8);
        run_phase(0, 0, 0, 0);
        check("to.pulse_count", 32'(n_tout_seen), 32'd1);
        check("to.after_period", 32'(meas_if.period), 32'd20);
        check("to.after_high", 32'(meas_if.high), 32'd5);

        ph = "en_drop_high";
        add_run(1'b0, 6); add_pwm(2, 4, 8); add_run(1'b1, 40);
        run_phase(1, 0, 0, 0);
        ph = "en_rearm_high";
        add_run(1'b1, 10); add_run(1'b0, 8); add_pwm(2, 4, 8);
        run_phase(1, 0, 0, 0);
        check("rearm.period", 32'(meas_if.period), 32'd12);
        check("rearm.high", 32'(meas_if.high), 32'd4);

        for (int p = 0; p < 8; p++) begin
            ph  = $sformatf("rand%0d", p);
            th  = int'($urandom_range(0, 3));
            np  = int'($urandom_range(3, 7));
            lvl = int'($urandom_range(0, 1));
            add_run(1'(lvl), int'($urandom_range(8, 15)));
            for (int i = 0; i < 2 * np; i++) begin
                add_run(1'(lvl + i + 1), int'($urandom_range(th + 1, th + 12)));
            end
            add_run(1'(lvl + 2 * np + 1), 8 + th);
            run_phase(th, 1, 0, 0);
        end

        ph = "reset_mid_low";
        add_run(1'b0, 6); add_pwm(2, 3, 7); add_run(1'b1, 3); add_run(1'b0, 20);
        run_phase(0, 3, 0, 40);
        check("rst.valid_after", 32'(meas_if.meas_valid), 32'd0);
        check("rst.period_after", 32'(meas_if.period), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
